// File: rtl/debug_run_ctrl.sv
// Debug run controller: gates the core clock-enable for halt / single-step /
// free-run / run-to-breakpoint operation, with a bank of PC breakpoints.
module debug_run_ctrl #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             bp_wr_en,
  input  logic [IDX_W-1:0] bp_wr_idx,
  input  logic [PC_W-1:0]  bp_wr_addr,
  input  logic             bp_wr_arm,
  input  logic [PC_W-1:0]  pc_in,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [IDX_W-1:0] bp_hit_idx,
  output logic             cmd_err,
  output logic [CNT_W-1:0] cycles_run
);

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_STEP,
    ST_RUN,
    ST_RUN_BP
  } state_e;

  typedef enum logic [1:0] {
    OP_HALT,
    OP_STEP_N,
    OP_RUN,
    OP_RUN_TO_BP
  } op_e;

  typedef enum logic [1:0] {
    CAUSE_RESET,
    CAUSE_CMD,
    CAUSE_COUNT,
    CAUSE_BP
  } cause_e;

  state_e                        state_q, state_d;
  cause_e                        cause_q, cause_d;
  logic [CNT_W-1:0]              remaining_q, remaining_d;
  logic [CNT_W-1:0]              cycles_q, cycles_d;
  logic [IDX_W-1:0]              hit_idx_q, hit_idx_d;
  logic                          err_q, err_d;
  logic                          first_q, first_d;
  logic [NUM_BP-1:0][PC_W-1:0]   bp_addr_q, bp_addr_d;
  logic [NUM_BP-1:0]             bp_arm_q, bp_arm_d;

  logic             bp_match;
  logic [IDX_W-1:0] bp_lowest;
  logic             bp_check;
  logic             bp_halt;
  logic             halt_cmd;
  logic             running;

  // Scan from the top down so the lowest matching channel wins.
  always_comb begin
    bp_match  = 1'b0;
    bp_lowest = '0;
    for (int unsigned i = NUM_BP; i > 0; i--) begin
      if (bp_arm_q[i-1] && (pc_in == bp_addr_q[i-1])) begin
        bp_match  = 1'b1;
        bp_lowest = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    running  = (state_q != ST_HALTED);
    bp_check = (state_q == ST_STEP) || ((state_q == ST_RUN_BP) && !first_q);
    bp_halt  = bp_check && bp_match;
    halt_cmd = cmd_valid && (cmd_op == OP_HALT);
    core_en  = running && !bp_halt && !halt_cmd;
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    remaining_d = remaining_q;
    hit_idx_d   = hit_idx_q;
    first_d     = 1'b0;
    err_d       = cmd_valid && (cmd_op != OP_HALT) && running;
    cycles_d    = (core_en && (cycles_q != '1)) ? cycles_q + CNT_W'(1) : cycles_q;
    bp_addr_d   = bp_addr_q;
    bp_arm_d    = bp_arm_q;

    if (bp_wr_en && (32'(bp_wr_idx) < NUM_BP)) begin
      bp_addr_d[bp_wr_idx] = bp_wr_addr;
      bp_arm_d[bp_wr_idx]  = bp_wr_arm;
    end

    if (state_q == ST_HALTED) begin
      if (cmd_valid) begin
        case (cmd_op)
          OP_STEP_N: begin
            remaining_d = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
            cycles_d    = '0;
            state_d     = ST_STEP;
          end
          OP_RUN: begin
            cycles_d = '0;
            state_d  = ST_RUN;
          end
          OP_RUN_TO_BP: begin
            cycles_d = '0;
            first_d  = 1'b1;
            state_d  = ST_RUN_BP;
          end
          default: ;
        endcase
      end
    end else if (bp_halt) begin
      state_d   = ST_HALTED;
      cause_d   = CAUSE_BP;
      hit_idx_d = bp_lowest;
    end else if (halt_cmd) begin
      state_d = ST_HALTED;
      cause_d = CAUSE_CMD;
    end else if (state_q == ST_STEP) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_COUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HALTED;
      cause_q     <= CAUSE_RESET;
      remaining_q <= '0;
      cycles_q    <= '0;
      hit_idx_q   <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      bp_addr_q   <= '0;
      bp_arm_q    <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      remaining_q <= remaining_d;
      cycles_q    <= cycles_d;
      hit_idx_q   <= hit_idx_d;
      err_q       <= err_d;
      first_q     <= first_d;
      bp_addr_q   <= bp_addr_d;
      bp_arm_q    <= bp_arm_d;
    end
  end

  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = cause_q;
  assign bp_hit_idx = hit_idx_q;
  assign cmd_err    = err_q;
  assign cycles_run = cycles_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Bench for debug_run_ctrl: directed scenarios plus random commands, all
// checked cycle by cycle against a behavioural run-control model.
module tb_debug_run_ctrl;

  localparam int PC_W   = 32;
  localparam int NUM_BP = 4;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             bp_wr_en;
  logic [1:0]       bp_wr_idx;
  logic [PC_W-1:0]  bp_wr_addr;
  logic             bp_wr_arm;
  logic [PC_W-1:0]  pc_in;
  logic             core_en;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [1:0]       bp_hit_idx;
  logic             cmd_err;
  logic [CNT_W-1:0] cycles_run;

  always #5 clk = ~clk;

  debug_run_ctrl #(.PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .bp_wr_en   (bp_wr_en),
    .bp_wr_idx  (bp_wr_idx),
    .bp_wr_addr (bp_wr_addr),
    .bp_wr_arm  (bp_wr_arm),
    .pc_in      (pc_in),
    .core_en    (core_en),
    .halted     (halted),
    .halt_cause (halt_cause),
    .bp_hit_idx (bp_hit_idx),
    .cmd_err    (cmd_err),
    .cycles_run (cycles_run)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: mode 0 halted, 1 stepping, 2 free run, 3 run-to-breakpoint
  int          m_mode, m_rem, m_cyc, m_cause, m_idx;
  bit          m_first, m_err;
  logic [31:0] m_addr [NUM_BP];
  bit          m_arm  [NUM_BP];
  int          en_seen;
  bit          obs_en;

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_cyc = 0; m_cause = 0; m_idx = 0;
    m_first = 0; m_err = 0;
    for (int i = 0; i < NUM_BP; i++) begin
      m_addr[i] = '0;
      m_arm[i]  = 0;
    end
  endtask

  task automatic tick(input bit v, input int op, input int cnt, input logic [31:0] pc,
                      input bit we, input int widx, input logic [31:0] waddr, input bit warm);
    bit hit, hcmd, en, nerr;
    int lo;
    @(negedge clk);
    cmd_valid  = v;
    cmd_op     = op[1:0];
    cmd_count  = cnt[CNT_W-1:0];
    pc_in      = pc;
    bp_wr_en   = we;
    bp_wr_idx  = widx[1:0];
    bp_wr_addr = waddr;
    bp_wr_arm  = warm;
    #1;
    hit = 0;
    lo  = 0;
    if (m_mode == 1 || (m_mode == 3 && !m_first))
      for (int i = NUM_BP - 1; i >= 0; i--)
        if (m_arm[i] && m_addr[i] == pc) begin
          hit = 1;
          lo  = i;
        end
    hcmd = v && (op == 0);
    en   = (m_mode != 0) && !hit && !hcmd;
    check("core_en", core_en, en);
    check("halted", halted, m_mode == 0);
    check("halt_cause", halt_cause, m_cause);
    check("bp_hit_idx", bp_hit_idx, m_idx);
    check("cmd_err", cmd_err, m_err);
    check("cycles_run", cycles_run, m_cyc);
    obs_en = core_en;
    if (core_en) en_seen++;
    @(posedge clk);
    nerr = v && (op != 0) && (m_mode != 0);
    if (en && m_cyc < CMAX) m_cyc++;
    if (m_mode == 0) begin
      m_first = 0;
      if (v) begin
        if (op == 1) begin m_rem = (cnt == 0) ? 1 : cnt; m_cyc = 0; m_mode = 1; end
        if (op == 2) begin m_cyc = 0; m_mode = 2; end
        if (op == 3) begin m_cyc = 0; m_mode = 3; m_first = 1; end
      end
    end else begin
      m_first = 0;
      if (hit) begin
        m_mode = 0; m_cause = 3; m_idx = lo;
      end else if (hcmd) begin
        m_mode = 0; m_cause = 1;
      end else if (m_mode == 1) begin
        if (m_rem == 1) begin m_mode = 0; m_cause = 2; end
        m_rem--;
      end
    end
    m_err = nerr;
    if (we) begin
      m_addr[widx] = waddr;
      m_arm[widx]  = warm;
    end
    #1;
  endtask

  task automatic cmd(input int op, input int cnt, input logic [31:0] pc);
    tick(1, op, cnt, pc, 0, 0, '0, 0);
  endtask

  task automatic idle(input logic [31:0] pc);
    tick(0, 0, 0, pc, 0, 0, '0, 0);
  endtask

  task automatic bpw(input int idx, input logic [31:0] addr, input bit arm);
    tick(0, 0, 0, '0, 1, idx, addr, arm);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_en"}, core_en, 0);
    check({tag, "_halted"}, halted, 1);
    check({tag, "_cause"}, halt_cause, 0);
    check({tag, "_idx"}, bp_hit_idx, 0);
    check({tag, "_err"}, cmd_err, 0);
    check({tag, "_cycles"}, cycles_run, 0);
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 0; cmd_op = '0; cmd_count = '0; pc_in = '0;
    bp_wr_en = 0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_arm = 0;
    model_reset();
    en_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // STEP_N 3
    en_seen = 0;
    cmd(1, 3, 0);
    repeat (4) idle(0);
    check("step3_en_cycles", en_seen, 3);
    check("step3_cause", halt_cause, 2);
    check("step3_cycles", cycles_run, 3);

    // STEP_N 0 behaves as 1
    en_seen = 0;
    cmd(1, 0, 0);
    repeat (3) idle(0);
    check("step0_en_cycles", en_seen, 1);
    check("step0_cause", halt_cause, 2);

    // Run to breakpoint on channel 1 at 0x10
    bpw(1, 32'h10, 1);
    cmd(3, 0, 0);
    en_seen = 0;
    for (int k = 0; k <= 4; k++) idle(32'(k * 4));
    check("bp_cycle_en", obs_en, 0);
    check("bp_en_cycles", en_seen, 4);
    check("bp_cause", halt_cause, 3);
    check("bp_idx", bp_hit_idx, 1);
    cmd(3, 0, 32'h10);
    idle(32'h10);
    check("resume_from_bp", obs_en, 1);
    idle(32'h14);
    check("resume_running", halted, 0);
    cmd(0, 0, 32'h18);
    check("halt_cause_cmd", halt_cause, 1);

    // RUN with HALT after 5 cycles; breakpoints ignored in RUN
    cmd(2, 0, 0);
    for (int k = 0; k < 5; k++) idle(32'(k * 4));
    cmd(0, 0, 32'h14);
    check("run5_cycles", cycles_run, 5);
    check("run5_cause", halt_cause, 1);
    cmd(2, 0, 0);
    idle(32'h10);
    check("run_ignores_bp", obs_en, 1);
    cmd(1, 4, 32'h14);
    check("err_cmd_en", obs_en, 1);
    check("err_pulse", cmd_err, 1);
    check("err_still_run", halted, 0);
    idle(32'h18);
    check("err_clears", cmd_err, 0);
    cmd(0, 0, 0);

    // Simultaneous HALT and breakpoint, two channels matching
    bpw(0, 32'h20, 1);
    bpw(2, 32'h20, 1);
    cmd(3, 0, 0);
    idle(0);
    cmd(0, 0, 32'h20);
    check("bp_cmd_en", obs_en, 0);
    check("bp_over_cmd_cause", halt_cause, 3);
    check("bp_lowest_idx", bp_hit_idx, 0);
    cmd(0, 0, 0);
    check("halt_when_halted_cause", halt_cause, 3);
    check("halt_when_halted_err", cmd_err, 0);

    // Breakpoint written mid-run: old contents in the write cycle
    cmd(3, 0, 0);
    idle(0);
    tick(0, 0, 0, 32'h30, 1, 3, 32'h30, 1);
    check("wr_cycle_old_bp", obs_en, 1);
    idle(32'h30);
    check("new_bp_hit_en", obs_en, 0);
    check("new_bp_idx", bp_hit_idx, 3);

    // Saturating cycle counter
    cmd(2, 0, 0);
    repeat (300) idle(0);
    check("sat_cycles", cycles_run, CMAX);
    cmd(0, 0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
           32'($urandom_range(0, 15) * 4), $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 3)), 32'($urandom_range(0, 15) * 4), $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset during RUN
    cmd(0, 0, 0);
    bpw(1, 32'h10, 1);
    bpw(0, 32'h20, 1);
    cmd(2, 0, 0);
    idle(0);
    idle(4);
    @(negedge clk);
    cmd_valid = 0;
    bp_wr_en  = 0;
    pc_in     = 32'h8;
    #1;
    check("pre_reset_running", core_en, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrun");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cmd(3, 0, 0);
    idle(32'h10);
    idle(32'h10);
    check("bp1_disarmed", obs_en, 1);
    idle(32'h20);
    check("bp0_disarmed", obs_en, 1);
    cmd(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
